music_sequencer: RTL and testbench
==================================

// Module: music_sequencer
// PURPOSE
//  Parametrised multi-channel tune player: beat-tick divider, beat-index sequencer with play/pause/stop/loop
//  control, and one square-wave tone generator per channel. Drives an external tone ROM via beat_idx, takes
//  back per-channel half-periods, and produces per-channel and time-multiplexed audio for the buzzer/amp.
//  Sits between the top-level control FSM (car modes) and the audio output pins.
// PARAMETERS
//  BEAT_DIV  6_250_000  clk cycles per beat (16 beats/s at 100 MHz); >=2
//  SONG_LEN  661        beats in the song; last index = SONG_LEN-1
//  IDX_W     10         beat_idx width; 2**IDX_W >= SONG_LEN
//  CH        2          number of tone channels, 1..8
//  HP_W      20         half-period width (clk cycles)
// PORTS
//  clk       in   1        system clock
//  reset     in   1        synchronous, active-high
//  play      in   1        level; start from IDLE/DONE, resume from PAUSED
//  pause     in   1        level; hold position while PLAYING
//  stop      in   1        pulse; return to IDLE, index 0
//  loop      in   1        1: wrap to index 0 after last beat; 0: stop in DONE
//  half_i    in   CH*HP_W  per-channel half-period from tone ROM, ch0 in LSBs; 0 = rest
//  beat_idx  out  IDX_W    current beat index to tone ROM
//  beat_tick out  1        1-cycle pulse on every beat advance
//  tone_o    out  CH       per-channel square wave
//  mix_o     out  1        tone_o[sel]; sel increments mod CH every clk
//  busy      out  1        1 in PLAYING or PAUSED
//  done      out  1        1-cycle pulse entering DONE
// BEHAVIOUR
//  Reset: state=IDLE, beat_idx=0, div cnt=0, beat_tick=0, tone_o=0, sel=0, mix_o=0, busy=0, done=0.
//  FSM: IDLE -play-> PLAYING; PLAYING -pause-> PAUSED; PAUSED -(play & !pause)-> PLAYING;
//   PLAYING -last beat & !loop-> DONE; DONE -play-> PLAYING at index 0; any -stop-> IDLE.
//   Priority per cycle: reset > stop > pause > play.
//  Divider: counts 0..BEAT_DIV-1 only in PLAYING; at BEAT_DIV-1 -> 0, beat_tick=1 next cycle, beat_idx advances.
//   PAUSED freezes divider and beat_idx; tone_o holds current level (phase counters frozen).
//  Wrap: at beat_idx==SONG_LEN-1 with tick: loop=1 -> idx 0, stay PLAYING; loop=0 -> DONE, idx held, done=1.
//  Entering PLAYING from IDLE/DONE: idx=0, divider=0; first tick BEAT_DIV cycles after entry.
//  Tone latch: half_i sampled 1 cycle after beat_idx changes (ROM is combinational) and on PLAYING entry.
//   If latched half for a channel differs from previous: phase cnt=0, tone_o[c]=0 (clean restart);
//   if equal: phase continues (legato, no glitch).
//  Phase: per channel cnt counts 0..half-1, toggles tone_o[c] at half-1; half=0 -> tone_o[c]=0, cnt=0.
//   half=1 -> toggles every clk.
//  IDLE/DONE: tone_o=0, mix_o=0. stop mid-note: tone_o=0 next cycle.
//  mix_o registered: mix_o <= tone_o[sel] (1-cycle latency); sel wraps CH-1 -> 0; CH=1 -> mix_o=tone_o[0].
//  All outputs registered; no combinational input->output path.
// CONFIGURATION
//  MUSIC_SEQ_TEMPO_EN defined: extra input tempo_div [31:0]; divider terminal = tempo_div-1, sampled
//   only at beat boundaries and PLAYING entry; tempo_div<2 treated as 2.
//  Undefined: port absent; terminal fixed at BEAT_DIV-1.
// TESTING  (BEAT_DIV=4, SONG_LEN=3, CH=2, HP_W=8)
//  reset 3 cycles -> all outputs 0, state IDLE; play held 1 cycle -> busy=1, beat_tick every 4 clks, idx 0,1,2.
//  loop=0 -> after idx 2 tick: done=1 one cycle, busy=0, idx stays 2, tone_o=0.
//  loop=1 -> idx sequence 0,1,2,0,1 with beat_tick every 4 clks, done never asserted.
//  half_i ch0=3, ch1=0 -> tone_o[0] period 6 clks, tone_o[1]=0; mix_o alternates sampled channels.
//  pause at idx 1 for 10 clks -> idx, divider, tone_o frozen; release -> remaining cycles resume, no lost beat.
//  stop during note and simultaneous stop+play -> IDLE, idx 0, tone_o=0 next cycle (stop wins).

Source files
------------

// File: rtl/music_sequencer.sv
// -----------------------------------------------------------------------------
// music_sequencer
// Multi-channel tune player. A beat divider advances a beat index that drives
// an external combinational tone ROM. The ROM returns one half-period per
// channel, and each channel runs a square-wave generator from it. A registered
// round-robin mux folds all channels onto a single buzzer pin.
//
// Optional build macro: MUSIC_SEQ_TEMPO_EN adds the input tempo_div[31:0],
// which replaces the fixed BEAT_DIV beat length at run time.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   play              level: start from IDLE/DONE, resume from PAUSED
//   pause             level: hold position while PLAYING
//   stop              pulse: back to IDLE at index 0 (wins over pause/play)
//   loop              1: wrap to index 0 after the last beat; 0: end in DONE
//   half_i            per-channel half-period (clk cycles), ch0 in LSBs; 0 = rest
//   beat_idx          current beat index to the tone ROM
//   beat_tick         1-cycle pulse on every divider terminal count
//   tone_o            per-channel square wave
//   mix_o             tone_o[sel] registered, sel rotates every clk
//   busy              PLAYING or PAUSED
//   done              1-cycle pulse on entering DONE
//   state_o           FSM state (debug): 0 IDLE, 1 PLAYING, 2 PAUSED, 3 DONE
//
// Control semantics: there is no valid/ready handshake. play and pause are
// sampled as levels on every clock. stop is a pulse. The per-cycle priority is
// reset > stop > pause > play. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module music_sequencer #(
    parameter int BEAT_DIV = 6_250_000,
    parameter int SONG_LEN = 661,
    parameter int IDX_W    = 10,
    parameter int CH       = 2,
    parameter int HP_W     = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               pause,
    input  logic               stop,
    input  logic               loop,
`ifdef MUSIC_SEQ_TEMPO_EN
    input  logic [31:0]        tempo_div,
`endif
    input  logic [CH*HP_W-1:0] half_i,
    output logic [IDX_W-1:0]   beat_idx,
    output logic               beat_tick,
    output logic [CH-1:0]      tone_o,
    output logic               mix_o,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_PAUSED  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

`ifdef MUSIC_SEQ_TEMPO_EN
    localparam int DIV_W = 32;
`else
    localparam int DIV_W = $clog2(BEAT_DIV);
`endif
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CH - 1);
    localparam logic [DIV_W-1:0] FIXED_TERM = DIV_W'(BEAT_DIV - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              load_q, load_d;   // half_i is valid for the new index this cycle
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              mix_q, mix_d;
    logic [CH-1:0]     tone_q, tone_d;
    logic [HP_W-1:0]   half_q [CH];
    logic [HP_W-1:0]   half_d [CH];
    logic [HP_W-1:0]   cnt_q  [CH];
    logic [HP_W-1:0]   cnt_d  [CH];
    logic [DIV_W-1:0]  term;
    logic [DIV_W-1:0]  new_term;
    logic              start;
    logic              run;
    logic              beat_edge;
    logic [HP_W-1:0]   h_new;

`ifdef MUSIC_SEQ_TEMPO_EN
    logic [DIV_W-1:0]  term_q, term_d;
    assign new_term = (tempo_div < 32'd2) ? 32'd1 : tempo_div - 32'd1;
    assign term     = term_q;
`else
    assign new_term = FIXED_TERM;
    assign term     = FIXED_TERM;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        div_d     = div_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        start     = 1'b0;
        run       = 1'b0;
        beat_edge = 1'b0;
        h_new     = '0;
        // A pending ROM sample survives a pause so the new index is never skipped.
        load_d    = load_q;
        sel_d     = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
        mix_d     = tone_q[sel_q];
`ifdef MUSIC_SEQ_TEMPO_EN
        term_d    = term_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: if (play && !pause) start = 1'b1;
            S_PLAYING: begin
                if (pause) state_d = S_PAUSED;
                else       run = 1'b1;
            end
            S_PAUSED: if (play && !pause) state_d = S_PLAYING;
            default: state_d = S_IDLE;
        endcase

        if (run) begin
            load_d = 1'b0;
            if (div_q == term) begin
                div_d     = '0;
                tick_d    = 1'b1;
                beat_edge = 1'b1;
                if (idx_q == LAST_IDX) begin
                    if (loop) begin
                        idx_d  = '0;
                        load_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d  = idx_q + 1'b1;
                    load_d = 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        if (start) begin
            state_d   = S_PLAYING;
            idx_d     = '0;
            div_d     = '0;
            load_d    = 1'b1;
            beat_edge = 1'b1;
        end

`ifdef MUSIC_SEQ_TEMPO_EN
        if (beat_edge) term_d = new_term;
`endif

        if (stop) begin
            state_d = S_IDLE;
            idx_d   = '0;
            div_d   = '0;
            tick_d  = 1'b0;
            done_d  = 1'b0;
            load_d  = 1'b0;
        end

        busy_d = (state_d == S_PLAYING) || (state_d == S_PAUSED);

        tone_d = tone_q;
        for (int c = 0; c < CH; c++) begin
            half_d[c] = half_q[c];
            cnt_d[c]  = cnt_q[c];
            h_new     = half_i[c*HP_W +: HP_W];
            if (state_d == S_IDLE || state_d == S_DONE) begin
                half_d[c] = '0;
                cnt_d[c]  = '0;
                tone_d[c] = 1'b0;
            end else if (run) begin
                if (load_q && (h_new != half_q[c])) begin
                    // New pitch: restart phase from low so the note starts cleanly.
                    half_d[c] = h_new;
                    cnt_d[c]  = '0;
                    tone_d[c] = 1'b0;
                end else if (half_q[c] == '0) begin
                    cnt_d[c]  = '0;
                    tone_d[c] = 1'b0;
                end else if (cnt_q[c] >= half_q[c] - 1'b1) begin
                    cnt_d[c]  = '0;
                    tone_d[c] = ~tone_q[c];
                end else begin
                    cnt_d[c]  = cnt_q[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            div_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            sel_q   <= '0;
            mix_q   <= 1'b0;
            tone_q  <= '0;
            for (int c = 0; c < CH; c++) begin
                half_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
`ifdef MUSIC_SEQ_TEMPO_EN
            term_q  <= FIXED_TERM;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            sel_q   <= sel_d;
            mix_q   <= mix_d;
            tone_q  <= tone_d;
            for (int c = 0; c < CH; c++) begin
                half_q[c] <= half_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
`ifdef MUSIC_SEQ_TEMPO_EN
            term_q  <= term_d;
`endif
        end
    end

    assign beat_idx  = idx_q;
    assign beat_tick = tick_q;
    assign tone_o    = tone_q;
    assign mix_o     = mix_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_music_sequencer.sv
// -----------------------------------------------------------------------------
// tb_music_sequencer
// Directed bench for music_sequencer with BEAT_DIV=4, SONG_LEN=3, CH=2, HP_W=8.
// Edge En is the n-th rising edge after the edge that sampled play. Outputs are
// read 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_music_sequencer;
  localparam int IDX_W = 2;
  localparam int CH    = 2;
  localparam int HP_W  = 8;

  logic               clk;
  logic               reset;
  logic               play;
  logic               pause;
  logic               stop;
  logic               loop;
  logic [CH*HP_W-1:0] half_i;
  logic [IDX_W-1:0]   beat_idx;
  logic               beat_tick;
  logic [CH-1:0]      tone_o;
  logic               mix_o;
  logic               busy;
  logic               done;
  logic [1:0]         state_o;

  int n_cmp;
  int n_bad;
  logic sel_m;                  // reference round-robin selector
  logic [1:0] exp_q[$];         // expected tone_o stream

  music_sequencer #(
    .BEAT_DIV(4), .SONG_LEN(3), .IDX_W(IDX_W), .CH(CH), .HP_W(HP_W)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .pause(pause), .stop(stop),
    .loop(loop), .half_i(half_i), .beat_idx(beat_idx), .beat_tick(beat_tick),
    .tone_o(tone_o), .mix_o(mix_o), .busy(busy), .done(done), .state_o(state_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) sel_m <= 1'b0;
    else       sel_m <= ~sel_m;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; loop = 1'b0; half_i = '0;
    repeat (3) step();
    n_cmp++; if (beat_idx !== 2'd0)  begin n_bad++; $display("FAIL reset_idx: got %0d want 0", beat_idx); end
    n_cmp++; if (beat_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", beat_tick); end
    n_cmp++; if (tone_o !== 2'b00)   begin n_bad++; $display("FAIL reset_tone: got %b want 00", tone_o); end
    n_cmp++; if (mix_o !== 1'b0)     begin n_bad++; $display("FAIL reset_mix: got %b want 0", mix_o); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (state_o !== 2'd0)   begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_play_once();
    loop = 1'b0; half_i = '0;
    play = 1'b1; step(); play = 1'b0;   // E0
    n_cmp++; if (busy !== 1'b1)    begin n_bad++; $display("FAIL play_busy: got %b want 1", busy); end
    n_cmp++; if (state_o !== 2'd1) begin n_bad++; $display("FAIL play_state: got %0d want 1", state_o); end
    n_cmp++; if (beat_idx !== 2'd0) begin n_bad++; $display("FAIL play_idx0: got %0d want 0", beat_idx); end
    for (int b = 1; b <= 2; b++) begin
      repeat (3) begin
        step();
        n_cmp++; if (beat_tick !== 1'b0) begin n_bad++; $display("FAIL play_notick: got %b want 0", beat_tick); end
      end
      step();
      n_cmp++; if (beat_tick !== 1'b1) begin n_bad++; $display("FAIL play_tick: got %b want 1", beat_tick); end
      n_cmp++; if (beat_idx !== 2'(b)) begin n_bad++; $display("FAIL play_idx: got %0d want %0d", beat_idx, b); end
    end
    repeat (3) step();
    step();                              // E12: last beat expires
    n_cmp++; if (done !== 1'b1)     begin n_bad++; $display("FAIL end_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL end_busy: got %b want 0", busy); end
    n_cmp++; if (beat_idx !== 2'd2) begin n_bad++; $display("FAIL end_idx: got %0d want 2", beat_idx); end
    n_cmp++; if (tone_o !== 2'b00)  begin n_bad++; $display("FAIL end_tone: got %b want 00", tone_o); end
    n_cmp++; if (state_o !== 2'd3)  begin n_bad++; $display("FAIL end_state: got %0d want 3", state_o); end
    step();
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL end_done_pulse: got %b want 0", done); end
    n_cmp++; if (beat_idx !== 2'd2) begin n_bad++; $display("FAIL end_idx_hold: got %0d want 2", beat_idx); end
  endtask

  task automatic test_loop();
    logic [1:0] seq [4];
    seq = '{2'd1, 2'd2, 2'd0, 2'd1};
    loop = 1'b1;
    play = 1'b1; step(); play = 1'b0;   // restart from DONE
    n_cmp++; if (beat_idx !== 2'd0) begin n_bad++; $display("FAIL loop_idx0: got %0d want 0", beat_idx); end
    for (int k = 0; k < 4; k++) begin
      repeat (3) begin
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL loop_done: got %b want 0", done); end
      end
      step();
      n_cmp++; if (beat_tick !== 1'b1) begin n_bad++; $display("FAIL loop_tick: got %b want 1", beat_tick); end
      n_cmp++; if (beat_idx !== seq[k]) begin n_bad++; $display("FAIL loop_idx: got %0d want %0d", beat_idx, seq[k]); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL loop_done_wrap: got %b want 0", done); end
    end
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++; if (state_o !== 2'd0)  begin n_bad++; $display("FAIL loop_stop_state: got %0d want 0", state_o); end
    n_cmp++; if (beat_idx !== 2'd0) begin n_bad++; $display("FAIL loop_stop_idx: got %0d want 0", beat_idx); end
  endtask

  // ch0 half=3 gives a 6-clk period; the ROM value is first sampled at E1.
  task automatic test_tone();
    logic [1:0] e;
    logic [1:0] prev;
    half_i = {8'd0, 8'd3}; loop = 1'b1;
    for (int n = 1; n <= 24; n++) exp_q.push_back({1'b0, 1'(((n - 1) / 3) % 2)});
    play = 1'b1; step(); play = 1'b0;   // E0
    prev = 2'b00;
    for (int n = 1; n <= 24; n++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++; if (tone_o !== e) begin n_bad++; $display("FAIL tone_n%0d: got %b want %b", n, tone_o, e); end
      n_cmp++; if (mix_o !== prev[~sel_m]) begin n_bad++; $display("FAIL mix_n%0d: got %b want %b", n, mix_o, prev[~sel_m]); end
      prev = e;
    end
  endtask

  // Runs straight after test_tone, mid-note with tone_o[0]=1.
  task automatic test_stop_play();
    stop = 1'b1; play = 1'b1; step(); stop = 1'b0; play = 1'b0;
    n_cmp++; if (state_o !== 2'd0)  begin n_bad++; $display("FAIL sp_state: got %0d want 0", state_o); end
    n_cmp++; if (beat_idx !== 2'd0) begin n_bad++; $display("FAIL sp_idx: got %0d want 0", beat_idx); end
    n_cmp++; if (tone_o !== 2'b00)  begin n_bad++; $display("FAIL sp_tone: got %b want 00", tone_o); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL sp_busy: got %b want 0", busy); end
    step();
    n_cmp++; if (state_o !== 2'd0)  begin n_bad++; $display("FAIL sp_state_hold: got %0d want 0", state_o); end
    n_cmp++; if (mix_o !== 1'b0)    begin n_bad++; $display("FAIL sp_mix: got %b want 0", mix_o); end
  endtask

  task automatic test_pause();
    half_i = {8'd0, 8'd3}; loop = 1'b1;
    play = 1'b1; step(); play = 1'b0;   // E0
    repeat (5) step();                   // E5: idx 1, divider at 1, tone high
    n_cmp++; if (beat_idx !== 2'd1) begin n_bad++; $display("FAIL pz_pre_idx: got %0d want 1", beat_idx); end
    n_cmp++; if (tone_o !== 2'b01)  begin n_bad++; $display("FAIL pz_pre_tone: got %b want 01", tone_o); end
    pause = 1'b1; play = 1'b1;           // pause must beat play
    for (int k = 0; k < 10; k++) begin   // E6..E15
      step();
      n_cmp++; if (beat_idx !== 2'd1)  begin n_bad++; $display("FAIL pz_idx_k%0d: got %0d want 1", k, beat_idx); end
      n_cmp++; if (tone_o !== 2'b01)   begin n_bad++; $display("FAIL pz_tone_k%0d: got %b want 01", k, tone_o); end
      n_cmp++; if (beat_tick !== 1'b0) begin n_bad++; $display("FAIL pz_tick_k%0d: got %b want 0", k, beat_tick); end
      n_cmp++; if (state_o !== 2'd2)   begin n_bad++; $display("FAIL pz_state_k%0d: got %0d want 2", k, state_o); end
    end
    pause = 1'b0;
    step(); play = 1'b0;                 // E16: resume
    n_cmp++; if (state_o !== 2'd1)  begin n_bad++; $display("FAIL pz_resume_state: got %0d want 1", state_o); end
    n_cmp++; if (tone_o !== 2'b01)  begin n_bad++; $display("FAIL pz_resume_tone: got %b want 01", tone_o); end
    step();                              // E17
    n_cmp++; if (tone_o !== 2'b01)   begin n_bad++; $display("FAIL pz_e17_tone: got %b want 01", tone_o); end
    n_cmp++; if (beat_tick !== 1'b0) begin n_bad++; $display("FAIL pz_e17_tick: got %b want 0", beat_tick); end
    step();                              // E18
    n_cmp++; if (tone_o !== 2'b00)   begin n_bad++; $display("FAIL pz_e18_tone: got %b want 00", tone_o); end
    n_cmp++; if (beat_tick !== 1'b0) begin n_bad++; $display("FAIL pz_e18_tick: got %b want 0", beat_tick); end
    step();                              // E19
    n_cmp++; if (beat_tick !== 1'b1) begin n_bad++; $display("FAIL pz_e19_tick: got %b want 1", beat_tick); end
    n_cmp++; if (beat_idx !== 2'd2)  begin n_bad++; $display("FAIL pz_e19_idx: got %0d want 2", beat_idx); end
    repeat (2) step();                   // E21: mid-note again
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++; if (state_o !== 2'd0)  begin n_bad++; $display("FAIL pz_stop_state: got %0d want 0", state_o); end
    n_cmp++; if (tone_o !== 2'b00)  begin n_bad++; $display("FAIL pz_stop_tone: got %b want 00", tone_o); end
    n_cmp++; if (beat_idx !== 2'd0) begin n_bad++; $display("FAIL pz_stop_idx: got %0d want 0", beat_idx); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_play_once();
    test_loop();
    test_tone();
    test_stop_play();
    test_pause();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
